i2c_target_regs: RTL and testbench
==================================

Name: i2c_target_regs

Overview:
- I2C responder (target) with an internal 8-bit register file, addressed at a fixed 7-bit bus address.
- Pairs with i2c_master across an open-drain SCL/SDA bus. Oversamples SCL/SDA on a fast system clock.
- Supports pointer-then-data writes, sequential auto-increment reads, repeated START and STOP.
- Exposes a host-side read port and a write strobe to surrounding logic.

Parameters:
- ADDR, 7'h50, 7-bit bus address this target ACKs.
- NUM_REGS, 16, register count (2..256); localparam PTR_W = $clog2(NUM_REGS).

Ports:
- clk_i  input  1  system clock; must be >= 20x SCL frequency.
- rst_i  input  1  asynchronous, active-high reset.
- scl_i  input  1  raw bus SCL.
- sda_i  input  1  raw bus SDA.
- sda_oe_o  output  1  1 = pull SDA low; 0 = release.
- host_addr_i  input  PTR_W  host read index.
- host_rdata_o  output  8  combinational reg[host_addr_i].
- wr_strobe_o  output  1  one-cycle pulse on each register write.
- wr_addr_o  output  PTR_W  index written; valid with wr_strobe_o.
- busy_o  output  1  high from address ACK until STOP or non-matching START.

Behaviour:
- Reset values:
  - Outputs: sda_oe_o=0, wr_strobe_o=0, wr_addr_o=0, busy_o=0.
  - Internal: all regs=0, pointer=0, state IDLE.
- Input conditioning:
  - scl_i and sda_i pass through a 2-FF synchronizer plus a previous-sample register.
  - Edge/condition detection latency: 3 clk_i.
- Bus conditions (on synced signals):
  - START: SDA falls while SCL high.
  - STOP: SDA rises while SCL high.
  - Bits are sampled on SCL rising edges.
  - sda_oe_o changes only in the cycle after a detected SCL falling edge.
- States: IDLE, RCV_ADDR, ACK_ADDR, RCV_PTR, ACK_PTR, DATA_XFER, ACK_DATA, WAIT_STOP.
- State transitions:
  - IDLE: on START -> RCV_ADDR, bit counter=0.
  - RCV_ADDR: shift 8 bits (7 address + R/W).
    - Match -> ACK_ADDR, busy_o=1.
    - Mismatch -> WAIT_STOP.
  - ACK_ADDR: drive sda_oe_o=1 for the 9th SCL pulse; release on its falling edge.
    - R/W=0 -> RCV_PTR.
    - R/W=1 -> DATA_XFER (read).
  - RCV_PTR -> ACK_PTR: pointer <= byte[PTR_W-1:0]; always ACK.
    - Upper bits beyond PTR_W are discarded.
    - Pointer >= NUM_REGS is stored as-is (non-power-of-2 case).
  - DATA_XFER (write):
    - Shift in 8 bits, then ACK_DATA.
    - reg[ptr] <= byte; wr_strobe_o pulses with wr_addr_o=ptr.
    - Pointer increments.
  - DATA_XFER (read):
    - Load reg[ptr] on entry, MSB first; each bit is driven after an SCL falling edge (sda_oe_o = ~bit).
    - Pointer increments after the 8th bit.
  - ACK_DATA (read): release SDA and sample the master's bit on the 9th SCL rise.
    - ACK (0) -> next byte.
    - NACK (1) -> WAIT_STOP.
  - WAIT_STOP: SDA released; wait for STOP or START.
- Pointer rules:
  - Increment wraps NUM_REGS-1 -> 0.
  - Out-of-range pointer: writes ignored (no strobe, still ACKed); reads return 8'hFF.
- Boundary conditions:
  - STOP in any state -> IDLE, sda_oe_o=0, busy_o=0 next cycle; pointer retained.
  - START in any state (repeated START) -> RCV_ADDR; pointer retained; partial byte discarded, no write.
  - Reset mid-transfer -> sda_oe_o drops immediately (async); bus released.
  - Simultaneous host read and write of the same index: host_rdata_o shows the old value until the clock edge, then the new one.
  - General-call address 7'h00 is not ACKed.

Optional Feature:
- Macro: I2C_GLITCH_FILTER_EN.
- When defined:
  - A 3-sample majority filter is inserted after each synchronizer.
  - Pulses shorter than 2 clk_i are suppressed.
  - Detection latency becomes 5 clk_i.
- When undefined: no filter; latency stays 3 clk_i; all other behaviour is identical.

Decomposition:
- Shared package i2c_pkg:
  - states_t enum, widened to logic [3:0] to hold the new states. i2c_master and i2c_slave move to this package.
  - Constants I2C_ACK=1'b0, I2C_NACK=1'b1, I2C_BYTE_BITS=8.
- Sub-module i2c_sync_edge: synchronizer, optional filter, and rise/fall outputs. Instantiated once each for SCL and SDA.

Test Plan:
- Write ADDR=0x50 W, ptr=0x03, data 0xA5, 0x5A, STOP -> ACK on all 4 bytes; reg3=0xA5, reg4=0x5A; two wr_strobe_o pulses with addr 3 then 4.
- Addr 0x51 W -> no ACK (sda_oe_o stays 0) and no strobes until STOP.
- Write ptr=0x0F, repeated START, read 3 bytes with ACK, ACK, NACK -> returns reg15, reg0, reg1 (wrap); SDA released after NACK.
- Set ptr=0x0E, data 0x11; STOP mid-2nd-byte after 4 bits -> reg14=0x11, reg15 unchanged, busy_o=0, state IDLE.
- Assert rst_i while driving a read 0-bit -> sda_oe_o=0 same cycle; all regs read 0x00 afterwards.
- With I2C_GLITCH_FILTER_EN, inject a 1-clk SCL low glitch mid-byte -> bit count unaffected; the byte is received correctly.

Source files
------------

// File: rtl/i2c_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | i2c_pkg : shared I2C state encoding, bus constants and helpers        |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_RCV_ADDR  = 4'd1,
    ST_ACK_ADDR  = 4'd2,
    ST_RCV_PTR   = 4'd3,
    ST_ACK_PTR   = 4'd4,
    ST_DATA_XFER = 4'd5,
    ST_ACK_DATA  = 4'd6,
    ST_WAIT_STOP = 4'd7
  } states_t;

  localparam logic I2C_ACK       = 1'b0;
  localparam logic I2C_NACK      = 1'b1;
  localparam int   I2C_BYTE_BITS = 8;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_sync_edge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | i2c_sync_edge : 2-FF synchronizer with rise/fall detection            |
// | Optional majority glitch filter under I2C_GLITCH_FILTER_EN            |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module i2c_sync_edge
  import i2c_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;
  logic lvl;

  // Idle bus level is high, so everything resets to 1 to avoid false edges.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= raw_i;
      sync_q <= meta_q;
    end
  end

`ifdef I2C_GLITCH_FILTER_EN
  logic hist1_q;
  logic hist2_q;
  logic maj_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hist1_q <= 1'b1;
      hist2_q <= 1'b1;
      maj_q   <= 1'b1;
    end else begin
      hist1_q <= sync_q;
      hist2_q <= hist1_q;
      maj_q   <= maj3(sync_q, hist1_q, hist2_q);
    end
  end

  assign lvl = maj_q;
`else
  assign lvl = sync_q;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= lvl;
    end
  end

  assign level_o = lvl;
  assign rise_o  = lvl & ~prev_q;
  assign fall_o  = ~lvl & prev_q;

endmodule
`default_nettype wire

// File: rtl/i2c_target_regs.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | i2c_target_regs : I2C target with an 8-bit register file              |
// | Optional input glitch filter: define I2C_GLITCH_FILTER_EN             |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module i2c_target_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDR     = 7'h50,
  parameter int         NUM_REGS = 16,
  localparam int        PTR_W    = $clog2(NUM_REGS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_oe_o,
  input  logic [PTR_W-1:0] host_addr_i,
  output logic [7:0]       host_rdata_o,
  output logic             wr_strobe_o,
  output logic [PTR_W-1:0] wr_addr_o,
  output logic             busy_o
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_sync_edge u_scl_sync (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .raw_i   (scl_i),
    .level_o (scl_lvl),
    .rise_o  (scl_rise),
    .fall_o  (scl_fall)
  );

  i2c_sync_edge u_sda_sync (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .raw_i   (sda_i),
    .level_o (sda_lvl),
    .rise_o  (sda_rise),
    .fall_o  (sda_fall)
  );

  states_t          state_q;
  logic [7:0]       regs_q [NUM_REGS];
  logic [PTR_W-1:0] ptr_q;
  logic [2:0]       cnt_q;
  logic [7:0]       shift_q;
  logic             rw_q;
  logic             got_ack_q;
  logic             sda_oe_q;
  logic             wr_strobe_q;
  logic [PTR_W-1:0] wr_addr_q;
  logic             busy_q;

  logic             start_det, stop_det, last_bit;
  logic [7:0]       rx_byte_d;
  logic [PTR_W-1:0] ptr_inc_d;
  logic [7:0]       rd_byte_d;
  logic             ptr_in_range, host_in_range;

  assign start_det = scl_lvl & sda_fall;
  assign stop_det  = scl_lvl & sda_rise;
  assign last_bit  = (cnt_q == 3'(I2C_BYTE_BITS - 1));
  assign rx_byte_d = {shift_q[6:0], sda_lvl};
  assign ptr_inc_d = (ptr_q == PTR_W'(NUM_REGS - 1)) ? '0 : ptr_q + 1'b1;

  // Only a non-power-of-two register count can leave the pointer out of range.
  if (NUM_REGS == (1 << PTR_W)) begin : g_range_full
    assign ptr_in_range  = 1'b1;
    assign host_in_range = 1'b1;
  end else begin : g_range_cmp
    assign ptr_in_range  = (ptr_q < PTR_W'(NUM_REGS));
    assign host_in_range = (host_addr_i < PTR_W'(NUM_REGS));
  end

  assign rd_byte_d    = ptr_in_range ? regs_q[ptr_q] : 8'hFF;
  assign host_rdata_o = host_in_range ? regs_q[host_addr_i] : 8'hFF;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      shift_q     <= '0;
      rw_q        <= 1'b0;
      got_ack_q   <= 1'b0;
      sda_oe_q    <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      busy_q      <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      wr_strobe_q <= 1'b0;
      if (stop_det) begin
        state_q  <= ST_IDLE;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b0;
      end else if (start_det) begin
        state_q  <= ST_RCV_ADDR;
        cnt_q    <= '0;
        sda_oe_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: sda_oe_q <= 1'b0;

          ST_RCV_ADDR: begin
            if (scl_rise) begin
              shift_q <= rx_byte_d;
              cnt_q   <= cnt_q + 3'd1;
              if (last_bit) begin
                if (rx_byte_d[7:1] == ADDR && ADDR != 7'h00) begin
                  state_q <= ST_ACK_ADDR;
                  rw_q    <= rx_byte_d[0];
                  busy_q  <= 1'b1;
                end else begin
                  state_q <= ST_WAIT_STOP;
                  busy_q  <= 1'b0;
                end
              end
            end
          end

          // First SCL fall starts the ACK pulse, the next one ends it.
          ST_ACK_ADDR: begin
            if (scl_fall) begin
              if (!sda_oe_q) begin
                sda_oe_q <= 1'b1;
              end else begin
                cnt_q <= '0;
                if (rw_q) begin
                  shift_q  <= rd_byte_d;
                  sda_oe_q <= ~rd_byte_d[7];
                  state_q  <= ST_DATA_XFER;
                end else begin
                  sda_oe_q <= 1'b0;
                  state_q  <= ST_RCV_PTR;
                end
              end
            end
          end

          ST_RCV_PTR: begin
            if (scl_rise) begin
              shift_q <= rx_byte_d;
              cnt_q   <= cnt_q + 3'd1;
              if (last_bit) begin
                ptr_q   <= rx_byte_d[PTR_W-1:0];
                state_q <= ST_ACK_PTR;
              end
            end
          end

          ST_ACK_PTR: begin
            if (scl_fall) begin
              if (!sda_oe_q) begin
                sda_oe_q <= 1'b1;
              end else begin
                sda_oe_q <= 1'b0;
                cnt_q    <= '0;
                state_q  <= ST_DATA_XFER;
              end
            end
          end

          ST_DATA_XFER: begin
            if (scl_rise) begin
              cnt_q <= cnt_q + 3'd1;
              if (!rw_q) shift_q <= rx_byte_d;
              if (last_bit) begin
                ptr_q     <= ptr_inc_d;
                got_ack_q <= 1'b0;
                state_q   <= ST_ACK_DATA;
                if (!rw_q && ptr_in_range) begin
                  regs_q[ptr_q] <= rx_byte_d;
                  wr_strobe_q   <= 1'b1;
                  wr_addr_q     <= ptr_q;
                end
              end
            end else if (scl_fall && rw_q) begin
              shift_q  <= {shift_q[6:0], shift_q[7]};
              sda_oe_q <= ~shift_q[6];
            end
          end

          ST_ACK_DATA: begin
            if (rw_q) begin
              if (scl_rise) begin
                if (sda_lvl == I2C_NACK) state_q <= ST_WAIT_STOP;
                else                     got_ack_q <= 1'b1;
              end else if (scl_fall) begin
                if (got_ack_q) begin
                  shift_q   <= rd_byte_d;
                  sda_oe_q  <= ~rd_byte_d[7];
                  cnt_q     <= '0;
                  got_ack_q <= 1'b0;
                  state_q   <= ST_DATA_XFER;
                end else begin
                  sda_oe_q <= 1'b0;
                end
              end
            end else if (scl_fall) begin
              if (!sda_oe_q) begin
                sda_oe_q <= 1'b1;
              end else begin
                sda_oe_q <= 1'b0;
                cnt_q    <= '0;
                state_q  <= ST_DATA_XFER;
              end
            end
          end

          ST_WAIT_STOP: sda_oe_q <= 1'b0;

          default: begin
            state_q  <= ST_IDLE;
            sda_oe_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sda_oe_o    = sda_oe_q;
  assign wr_strobe_o = wr_strobe_q;
  assign wr_addr_o   = wr_addr_q;
  assign busy_o      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_target_regs.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_i2c_target_regs : bus-level bench for i2c_target_regs              |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_i2c_target_regs;

  localparam int NUM_REGS = 16;
  localparam int PTR_W    = 4;
  localparam int Q        = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             m_scl = 1'b1;
  logic             m_sda = 1'b1;
  logic [PTR_W-1:0] host_addr = '0;
  logic             sda_bus, sda_oe, wr_strobe, busy;
  logic [PTR_W-1:0] wr_addr;
  logic [7:0]       host_rdata;

  assign sda_bus = m_sda & ~sda_oe;
  always #5 clk = ~clk;

  i2c_target_regs #(.ADDR(7'h50), .NUM_REGS(NUM_REGS)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .scl_i        (m_scl),
    .sda_i        (sda_bus),
    .sda_oe_o     (sda_oe),
    .host_addr_i  (host_addr),
    .host_rdata_o (host_rdata),
    .wr_strobe_o  (wr_strobe),
    .wr_addr_o    (wr_addr),
    .busy_o       (busy)
  );

  int         checks = 0;
  int         errors = 0;
  int         strobes[$];
  int         oe_cycles = 0;
  logic [7:0] prev_rdata = '0;
  logic [7:0] snap_before = '0;
  logic [7:0] snap_at = '0;
  int         snap_addr = -1;
  logic       snap_done = 1'b0;

  always @(negedge clk) begin
    if (wr_strobe) begin
      strobes.push_back(int'(wr_addr));
      if (!snap_done) begin
        snap_before = prev_rdata;
        snap_at     = host_rdata;
        snap_addr   = int'(wr_addr);
        snap_done   = 1'b1;
      end
    end
    if (sda_oe) oe_cycles++;
    prev_rdata = host_rdata;
  end

  typedef struct {
    logic [PTR_W-1:0] addr;
    logic [7:0]       exp;
  } rd_vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bus_start();
    m_sda = 1'b1; q();
    m_scl = 1'b1; q();
    m_sda = 1'b0; q();
    m_scl = 1'b0; q();
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; q();
    m_scl = 1'b1; q();
    m_sda = 1'b1; q(); q();
  endtask

  task automatic bit_out(input logic b);
    m_sda = b; q();
    m_scl = 1'b1; q(); q();
    m_scl = 1'b0; q();
  endtask

  task automatic bit_in(output logic b);
    m_sda = 1'b1; q();
    m_scl = 1'b1; q();
    b = sda_bus; q();
    m_scl = 1'b0; q();
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic nak);
    for (int i = 7; i >= 0; i--) bit_out(d[i]);
    bit_in(nak);
  endtask

  task automatic rd_byte(input logic nak, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      bit_in(b);
      d[i] = b;
    end
    bit_out(nak);
  endtask

  logic [7:0] mem [NUM_REGS];
  int         mptr;
  int         exp_str[$];

  initial begin
    rd_vec_t    tbl [4];
    logic       nak;
    logic [7:0] d, pbyte;
    int         n, base, oe0;

    tbl[0] = '{addr: 4'd3, exp: 8'hA5};
    tbl[1] = '{addr: 4'd4, exp: 8'h5A};
    tbl[2] = '{addr: 4'd2, exp: 8'h00};
    tbl[3] = '{addr: 4'd5, exp: 8'h00};

    repeat (4) @(negedge clk);
    chk("rst_sda_oe", 32'(sda_oe), 0);
    chk("rst_strobe", 32'(wr_strobe), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_wr_addr", 32'(wr_addr), 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_reg0", 32'(host_rdata), 0);

    // Basic pointer-then-data write, host port watching index 3.
    host_addr = 4'd3;
    bus_start();
    wr_byte(8'hA0, nak); chk("t1_addr_ack", 32'(nak), 0);
    chk("t1_busy", 32'(busy), 1);
    wr_byte(8'h03, nak); chk("t1_ptr_ack", 32'(nak), 0);
    wr_byte(8'hA5, nak); chk("t1_d0_ack", 32'(nak), 0);
    wr_byte(8'h5A, nak); chk("t1_d1_ack", 32'(nak), 0);
    bus_stop();
    chk("t1_busy_stop", 32'(busy), 0);
    chk("t1_nstrobe", 32'(strobes.size()), 2);
    if (strobes.size() >= 2) begin
      chk("t1_strobe0", 32'(strobes[0]), 3);
      chk("t1_strobe1", 32'(strobes[1]), 4);
    end
    for (int i = 0; i < 4; i++) begin
      host_addr = tbl[i].addr; #1;
      chk("t1_readback", 32'(host_rdata), 32'(tbl[i].exp));
    end
    chk("t1_snap_addr", 32'(snap_addr), 3);
    chk("t1_snap_old", 32'(snap_before), 0);
    chk("t1_snap_new", 32'(snap_at), 'hA5);

    // Wrong address and general call are ignored.
    oe0 = oe_cycles;
    bus_start();
    wr_byte(8'hA2, nak); chk("t2_addr_nak", 32'(nak), 1);
    chk("t2_busy", 32'(busy), 0);
    wr_byte(8'h03, nak); chk("t2_ptr_nak", 32'(nak), 1);
    wr_byte(8'hFF, nak); chk("t2_data_nak", 32'(nak), 1);
    bus_stop();
    bus_start();
    wr_byte(8'h00, nak); chk("t2_gencall_nak", 32'(nak), 1);
    bus_stop();
    chk("t2_no_oe", 32'(oe_cycles - oe0), 0);
    chk("t2_no_strobe", 32'(strobes.size()), 2);

    // Wrapping write with upper pointer bits set.
    bus_start();
    wr_byte(8'hA0, nak);
    wr_byte(8'hFF, nak); chk("t3_ptr_ack", 32'(nak), 0);
    wr_byte(8'hC7, nak);
    wr_byte(8'h81, nak);
    wr_byte(8'h3E, nak); chk("t3_last_ack", 32'(nak), 0);
    bus_stop();
    chk("t3_nstrobe", 32'(strobes.size()), 5);
    if (strobes.size() >= 5) begin
      chk("t3_strobe_wrap", 32'(strobes[3]), 0);
      chk("t3_strobe_last", 32'(strobes[4]), 1);
    end

    // Set pointer, repeated START, wrapping read.
    bus_start();
    wr_byte(8'hA0, nak);
    wr_byte(8'h0F, nak);
    bus_start();
    wr_byte(8'hA1, nak); chk("t4_raddr_ack", 32'(nak), 0);
    rd_byte(1'b0, d); chk("t4_rd15", 32'(d), 'hC7);
    rd_byte(1'b0, d); chk("t4_rd0", 32'(d), 'h81);
    rd_byte(1'b1, d); chk("t4_rd1", 32'(d), 'h3E);
    chk("t4_released", 32'(sda_oe), 0);
    chk("t4_busy_nak", 32'(busy), 1);
    bus_stop();
    chk("t4_busy_stop", 32'(busy), 0);
    chk("t4_no_strobe", 32'(strobes.size()), 5);

    // STOP in the middle of a data byte.
    bus_start();
    wr_byte(8'hA0, nak);
    wr_byte(8'h0E, nak);
    wr_byte(8'h11, nak);
    bit_out(1'b1); bit_out(1'b0); bit_out(1'b1); bit_out(1'b0);
    bus_stop();
    host_addr = 4'd14; #1; chk("t5_reg14", 32'(host_rdata), 'h11);
    host_addr = 4'd15; #1; chk("t5_reg15", 32'(host_rdata), 'hC7);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_nstrobe", 32'(strobes.size()), 6);

    // Reset while the target is driving a 0 data bit.
    bus_start();
    wr_byte(8'hA0, nak);
    wr_byte(8'h04, nak);
    bus_start();
    wr_byte(8'hA1, nak);
    q();
    chk("t6_driving", 32'(sda_oe), 1);
    #2 rst = 1'b1;
    #1 chk("t6_async_release", 32'(sda_oe), 0);
    m_scl = 1'b1; m_sda = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("t6_busy", 32'(busy), 0);
    for (int i = 0; i < NUM_REGS; i++) begin
      host_addr = PTR_W'(i); #1;
      chk("t6_reg_cleared", 32'(host_rdata), 0);
    end

    // Randomized transactions against a register-array model.
    for (int i = 0; i < NUM_REGS; i++) mem[i] = 8'h00;
    mptr = 0;
    base = strobes.size();
    for (int t = 0; t < 12; t++) begin
      n = $urandom_range(1, 4);
      pbyte = 8'($urandom);
      bus_start();
      if ($urandom_range(0, 1) == 1) begin
        wr_byte(8'hA0, nak); chk("rnd_waddr_ack", 32'(nak), 0);
        wr_byte(pbyte, nak); chk("rnd_ptr_ack", 32'(nak), 0);
        mptr = int'(pbyte) % NUM_REGS;
        for (int k = 0; k < n; k++) begin
          d = 8'($urandom);
          wr_byte(d, nak); chk("rnd_data_ack", 32'(nak), 0);
          mem[mptr] = d;
          exp_str.push_back(mptr);
          mptr = (mptr + 1) % NUM_REGS;
        end
      end else begin
        if ($urandom_range(0, 1) == 1) begin
          wr_byte(8'hA0, nak);
          wr_byte(pbyte, nak);
          mptr = int'(pbyte) % NUM_REGS;
          bus_start();
        end
        wr_byte(8'hA1, nak); chk("rnd_raddr_ack", 32'(nak), 0);
        for (int k = 0; k < n; k++) begin
          rd_byte(k == n - 1, d);
          chk("rnd_read", 32'(d), 32'(mem[mptr]));
          mptr = (mptr + 1) % NUM_REGS;
        end
      end
      bus_stop();
    end
    chk("rnd_nstrobe", 32'(strobes.size() - base), 32'(exp_str.size()));
    for (int i = 0; i < exp_str.size() && base + i < strobes.size(); i++)
      chk("rnd_strobe_addr", 32'(strobes[base + i]), 32'(exp_str[i]));
    for (int i = 0; i < NUM_REGS; i++) begin
      host_addr = PTR_W'(i); #1;
      chk("rnd_host_read", 32'(host_rdata), 32'(mem[i]));
    end

`ifdef I2C_GLITCH_FILTER_EN
    // One-clock SCL low glitch in the middle of a byte must be ignored.
    bus_start();
    wr_byte(8'hA0, nak);
    wr_byte(8'h07, nak);
    d = 8'hC3;
    for (int i = 7; i >= 0; i--) begin
      m_sda = d[i]; q();
      m_scl = 1'b1; q();
      if (i == 4) begin
        @(negedge clk) m_scl = 1'b0;
        @(negedge clk) m_scl = 1'b1;
      end
      q();
      m_scl = 1'b0; q();
    end
    bit_in(nak); chk("glitch_ack", 32'(nak), 0);
    bus_stop();
    host_addr = 4'd7; #1; chk("glitch_reg7", 32'(host_rdata), 'hC3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
